// File: rtl/if_stage.sv
// Instruction fetch stage: issues one fetch at a time, parks a returned word while
// decode is stalled, and applies branch redirects after the delay-slot word arrives.
module if_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8
);

  localparam int unsigned XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_3000);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] hold_buf;
  logic            redir_pend;
  logic [XLEN-1:0] redir_tgt;

  logic            fetch;
  logic            advance;
  logic            take_rdata;
  logic            park;
  logic            bubble;
  logic            redir_ok;
  logic [XLEN-1:0] pc_base;
  logic [XLEN-1:0] next_pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ISSUE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (imem_rvalid) state_nxt = stall ? HOLD : ISSUE;
      HOLD:    if (!stall) state_nxt = ISSUE;
      default: state_nxt = ISSUE;
    endcase
  end

  // Per-state control decode
  always_comb begin
    fetch      = 1'b0;
    advance    = 1'b0;
    take_rdata = 1'b0;
    park       = 1'b0;
    bubble     = 1'b0;
    case (state)
      ISSUE: fetch = 1'b1;
      WAIT: begin
        if (imem_rvalid && !stall) begin
          advance    = 1'b1;
          take_rdata = 1'b1;
        end else if (imem_rvalid) begin
          park = 1'b1;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD:    advance = !stall;
      default: fetch = 1'b0;
    endcase
  end

  assign imem_req  = fetch & reset;
  assign imem_addr = pc;
  assign id_pc8    = id_pc + XLEN'(8);

  // A live redirect wins over a parked one; targets are always word aligned
  assign redir_ok = redirect & ~stall & id_valid;
  assign pc_base  = redir_ok   ? redirect_pc :
                    redir_pend ? redir_tgt   : pc + XLEN'(4);
  assign next_pc  = pc_base & ~XLEN'(3);

  // PC and parked-redirect bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= '0;
    end else if (advance) begin
      pc         <= next_pc;
      redir_pend <= 1'b0;
    end else if (redir_ok) begin
      redir_pend <= 1'b1;
      redir_tgt  <= redirect_pc;
    end
  end

  // IF/ID register and stall buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_buf <= '0;
      id_valid <= 1'b0;
      id_instr <= '0;
      id_pc    <= '0;
    end else begin
      if (park) hold_buf <= imem_rdata;
      if (advance) begin
        id_valid <= 1'b1;
        id_instr <= take_rdata ? imem_rdata : hold_buf;
        id_pc    <= pc;
      end else if (bubble) begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: a transaction-level fetch model predicts each
// cycle's request and IF/ID contents; a monitor pops and compares on every cycle.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;

  if_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: fetch bookkeeping in transaction terms
  bit          m_req;        // a request goes out this cycle
  bit          m_out;        // a request is in flight
  bit          m_buffered;   // a returned word waits for decode
  logic [31:0] m_buf;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  bit          m_pend;
  logic [31:0] m_tgt;

  bit mem_busy   = 1'b0;
  int mem_cnt    = 0;
  bit prev_rst   = 1'b1;
  bit first_done = 1'b0;

  function automatic void model_reset();
    m_pc = 32'h0000_3000; m_req = 1'b1; m_out = 1'b0; m_buffered = 1'b0;
    m_buf = '0; m_v = 1'b0; m_instr = '0; m_ipc = '0; m_pend = 1'b0; m_tgt = '0;
  endfunction

  function automatic void model_step(input bit st, input bit rd, input logic [31:0] rpc,
                                     input bit rv, input logic [31:0] rdat);
    bit          eff;
    bit          delivered;
    logic [31:0] dest;
    eff       = rd && !st && m_v;
    dest      = eff ? rpc : (m_pend ? m_tgt : m_pc + 32'd4);
    dest[1:0] = 2'b00;
    delivered = 1'b0;
    if (m_req) begin
      m_req = 1'b0;
      m_out = 1'b1;
    end else if (!st && (m_buffered || (m_out && rv))) begin
      m_instr    = m_buffered ? m_buf : rdat;
      m_ipc      = m_pc;
      m_v        = 1'b1;
      m_pc       = dest;
      m_req      = 1'b1;
      m_out      = 1'b0;
      m_buffered = 1'b0;
      delivered  = 1'b1;
    end else if (m_out && rv) begin
      m_buf      = rdat;
      m_buffered = 1'b1;
      m_out      = 1'b0;
    end else if (m_out && !st) begin
      m_v = 1'b0;
    end
    if (delivered) m_pend = 1'b0;
    else if (eff) begin
      m_pend = 1'b1;
      m_tgt  = rpc;
    end
  endfunction

  // One cycle: retire the previous cycle into the model, drive new inputs, push expectation.
  // lat = 0 picks a random memory latency; rnd enables random stall/redirect.
  task automatic do_cycle(input bit rst_now, input int lat, input bit rnd, input bit stale);
    if (!prev_rst) model_step(stall, redirect, redirect_pc, imem_rvalid, imem_rdata);
    if (rst_now) begin
      model_reset();
      mem_busy = 1'b0;
    end
    reset = !rst_now;

    stall       = rnd && ($urandom_range(0, 9) < 3);
    redirect    = rnd && ($urandom_range(0, 9) < 2);
    case ($urandom_range(0, 3))
      0:       redirect_pc = 32'hFFFF_FFFF;
      1:       redirect_pc = 32'hFFFF_FFF8;
      default: redirect_pc = $urandom;
    endcase

    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst_now && mem_busy) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        mem_busy    = 1'b0;
        if (!first_done) begin
          imem_rdata = 32'h3408_0001;
          first_done = 1'b1;
        end
      end
    end
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    if (!rst_now && m_req) begin
      mem_busy = 1'b1;
      mem_cnt  = (lat == 0) ? int'($urandom_range(1, 4)) : lat;
    end

    sb.push_back('{req: (m_req && !rst_now), addr: m_pc, v: m_v, instr: m_instr, pc: m_ipc});
    prev_rst = rst_now;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT outputs against the oldest expectation each cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (imem_req !== e.req) begin
          errors++;
          $display("FAIL imem_req: got %0b expected %0b at %0t", imem_req, e.req, $time);
        end
        if (e.req) begin
          checks++;
          if (imem_addr !== e.addr) begin
            errors++;
            $display("FAIL imem_addr: got %08h expected %08h at %0t", imem_addr, e.addr, $time);
          end
        end
        checks++;
        if (id_valid !== e.v) begin
          errors++;
          $display("FAIL id_valid: got %0b expected %0b at %0t", id_valid, e.v, $time);
        end
        checks++;
        if (id_instr !== e.instr) begin
          errors++;
          $display("FAIL id_instr: got %08h expected %08h at %0t", id_instr, e.instr, $time);
        end
        checks++;
        if (id_pc !== e.pc) begin
          errors++;
          $display("FAIL id_pc: got %08h expected %08h at %0t", id_pc, e.pc, $time);
        end
        checks++;
        if (id_pc8 !== e.pc + 32'd8) begin
          errors++;
          $display("FAIL id_pc8: got %08h expected %08h at %0t", id_pc8, e.pc + 32'd8, $time);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1, 1'b0, 1'b0);
    // Quiet start with single-cycle memory, then a 3-cycle-latency stretch
    for (int i = 0; i < 8; i++)  do_cycle(1'b0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 3, 1'b0, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if (i == 400 || i == 900) begin
        // Reset while a fetch is in flight, then present a stale response
        for (int k = 0; k < 10 && !m_out; k++) do_cycle(1'b0, 4, 1'b1, 1'b0);
        do_cycle(1'b1, 0, 1'b1, 1'b0);
        do_cycle(1'b1, 0, 1'b1, 1'b0);
        do_cycle(1'b0, 0, 1'b0, 1'b1);
      end else begin
        do_cycle(1'b0, 0, 1'b1, 1'b0);
      end
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
